// File: rtl/keypad_matrix_scanner.sv
// ROWSxCOLS keypad scanner: one-cold column drive, per-frame key resolution, debounce, valid/ready events.
// Define KEYPAD_REPEAT_EN to re-emit a held key after REPEAT_DELAY frames and then every REPEAT_RATE frames.
module keypad_matrix_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CLK_DIV      = 50000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 8,
  localparam int KW          = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [KW-1:0]   key_code,
  output logic            key_held,
  output logic            key_drop
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int NW = $clog2(DEBOUNCE + 1);

  if (CLK_DIV < 2 || DEBOUNCE < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_matrix_scanner: CLK_DIV and DEBOUNCE must be >= 2, repeat periods >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_HELD, ST_RELEASE} state_t;

  logic [DW-1:0] div;
  logic [CW-1:0] col;
  logic [1:0]    acc_z;
  logic [KW-1:0] acc_code;
  logic [1:0]    cur_z;
  logic [RW-1:0] cur_r;
  logic [KW-1:0] cur_code;
  logic [2:0]    sum_z;
  logic [1:0]    fr_z;
  logic [KW-1:0] fr_code;
  logic          sample, last_col, frame_end;
  logic          fr_none, fr_single, fr_match;

  state_t        state, state_n;
  logic [NW-1:0] cnt, cnt_n, cnt_inc;
  logic [KW-1:0] cand, cand_n;
  logic          emit;

`ifdef KEYPAD_REPEAT_EN
  localparam int PW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [PW-1:0] rep_cnt, rep_cnt_n, rep_inc;
  logic          rep_first, rep_first_n;
`endif

  always_comb begin
    col_out = '1;
    col_out[col] = 1'b0;
  end

  assign sample    = (div == DW'(CLK_DIV - 1));
  assign last_col  = (col == CW'(COLS - 1));
  assign frame_end = sample && last_col;

  // Zeros seen on the rows for the column currently driven; saturates at 2.
  always_comb begin
    cur_z = 2'd0;
    cur_r = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_in[r]) begin
        if (cur_z == 2'd0) cur_r = RW'(r);
        if (cur_z != 2'd2) cur_z = cur_z + 2'd1;
      end
    end
  end

  assign cur_code  = KW'(int'(cur_r) * COLS + int'(col));
  assign sum_z     = {1'b0, acc_z} + {1'b0, cur_z};
  assign fr_z      = (sum_z > 3'd1) ? 2'd2 : sum_z[1:0];
  assign fr_code   = (acc_z == 2'd1) ? acc_code : cur_code;
  assign fr_none   = (fr_z == 2'd0);
  assign fr_single = (fr_z == 2'd1);
  assign fr_match  = fr_single && (fr_code == cand);

  // Scan stage: divider, column walk and per-frame accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      col      <= '0;
      acc_z    <= 2'd0;
      acc_code <= '0;
    end else if (sample) begin
      div <= '0;
      col <= last_col ? '0 : col + 1'b1;
      if (last_col) begin
        acc_z    <= 2'd0;
        acc_code <= '0;
      end else begin
        acc_z    <= fr_z;
        acc_code <= fr_code;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  // Debounce stage: FSM evaluated once per frame end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    emit    = 1'b0;
    cnt_inc = cnt + 1'b1;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_n   = rep_cnt;
    rep_first_n = rep_first;
    rep_inc     = rep_cnt + 1'b1;
`endif
    if (frame_end) begin
      unique case (state)
        ST_IDLE: begin
          if (fr_single) begin
            cand_n  = fr_code;
            cnt_n   = NW'(1);
            state_n = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (fr_match) begin
            cnt_n = cnt_inc;
            if (cnt_inc == NW'(DEBOUNCE)) begin
              emit    = 1'b1;
              state_n = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_n   = '0;
              rep_first_n = 1'b0;
`endif
            end
          end else if (fr_single) begin
            cand_n = fr_code;
            cnt_n  = NW'(1);
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (fr_match) begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_inc == (rep_first ? PW'(REPEAT_RATE) : PW'(REPEAT_DELAY))) begin
              emit        = 1'b1;
              rep_cnt_n   = '0;
              rep_first_n = 1'b1;
            end else begin
              rep_cnt_n = rep_inc;
            end
`endif
          end else begin
            state_n = ST_RELEASE;
            cnt_n   = NW'(1);
          end
        end
        ST_RELEASE: begin
          if (fr_none) begin
            cnt_n = cnt_inc;
            if (cnt_inc == NW'(DEBOUNCE)) state_n = ST_IDLE;
          end else if (fr_match) begin
            state_n = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_n   = '0;
            rep_first_n = 1'b0;
`endif
          end else begin
            cnt_n = NW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cand  <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_cnt_n;
      rep_first <= rep_first_n;
`endif
    end
  end

  assign key_held = (state == ST_HELD) || (state == ST_RELEASE);

  // Event stage: single-entry valid/ready holding register; a busy register drops new events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_drop  <= 1'b0;
    end else begin
      key_drop <= 1'b0;
      if (key_valid && key_ready) begin
        key_valid <= emit;
        if (emit) key_code <= cand_n;
      end else if (emit) begin
        if (key_valid) begin
          key_drop <= 1'b1;
        end else begin
          key_valid <= 1'b1;
          key_code  <= cand_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a switch-matrix model closes rows against the driven column,
// expected key codes go into a queue and are matched against each accepted event.
module tb_keypad_matrix_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 4;
  localparam int FRAME = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_out;
  logic            key_valid;
  logic            key_ready;
  logic [KW-1:0]   key_code;
  logic            key_held;
  logic            key_drop;

  logic [15:0]     pressed;
  int              total = 0;
  int              bad = 0;
  int              drops = 0;
  int              exp_q[$];

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(4), .DEBOUNCE(3),
    .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_held(key_held), .key_drop(key_drop)
  );

  always #5 clk = ~clk;

  // A closed switch pulls its row low while its column is driven low.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS + c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic run_frames(input int n, input logic [15:0] keys);
    pressed = keys;
    repeat (n * FRAME) @(negedge clk);
  endtask

  function automatic logic [15:0] key(input int code);
    logic [15:0] k;
    k = '0;
    k[code] = 1'b1;
    return k;
  endfunction

  // Accept monitor: values settled after the negedge are what the next posedge sees.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #1;
      if (key_drop) drops++;
      if (rst_n && key_valid && key_ready) begin
        chk("evt_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("evt_code", int'(key_code), e);
        end
      end
    end
  end

  initial begin
    logic [3:0] exp_col;
    rst_n     = 1'b0;
    key_ready = 1'b1;
    pressed   = '0;
    repeat (3) @(negedge clk);
    chk("rst_col_out", int'(col_out), 4'b1110);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_code", int'(key_code), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_drop", int'(key_drop), 0);
    rst_n = 1'b1;

    // Idle scan: column walks every 4 clocks, nothing emitted
    for (int k = 0; k < 2 * FRAME; k++) begin
      exp_col = 4'b1111;
      exp_col[(k / 4) % 4] = 1'b0;
      chk("idle_col", int'(col_out), int'(exp_col));
      if (k % 4 == 3) chk("idle_valid", int'(key_valid), 0);
      @(negedge clk);
    end

    // Clean press of key 6 (row1/col2), latency one cycle after third frame end
    exp_q.push_back(6);
    run_frames(2, key(6));
    repeat (FRAME - 1) @(negedge clk);
    chk("press_early", int'(key_valid), 0);
    @(negedge clk);
    chk("press_valid", int'(key_valid), 1);
    chk("press_code", int'(key_code), 6);
    chk("press_held", int'(key_held), 1);
    @(negedge clk);
    chk("press_cleared", int'(key_valid), 0);
    repeat (FRAME - 1) @(negedge clk);
    run_frames(1, key(6));
    run_frames(3, '0);
    chk("release_held", int'(key_held), 0);

    // Bounce: on, off, on x3 yields one event only after three stable frames
    exp_q.push_back(6);
    run_frames(1, key(6));
    run_frames(1, '0);
    run_frames(2, key(6));
    chk("bounce_pending", exp_q.size(), 1);
    chk("bounce_held", int'(key_held), 0);
    run_frames(1, key(6));
    chk("bounce_held_after", int'(key_held), 1);
    run_frames(3, '0);

    // Two keys in one column: MULTI, never accepted
    run_frames(4, key(0) | key(4));
    chk("multi_held", int'(key_held), 0);
    chk("multi_valid", int'(key_valid), 0);
    run_frames(1, '0);

    // Consumer stalled: key 5 held pending, key 9 dropped
    key_ready = 1'b0;
    exp_q.push_back(5);
    run_frames(3, key(5));
    chk("stall_valid", int'(key_valid), 1);
    chk("stall_code5", int'(key_code), 5);
    run_frames(3, '0);
    chk("stall_released", int'(key_held), 0);
    run_frames(3, key(9));
    @(negedge clk);
    chk("drop_count", drops, 1);
    chk("drop_code_kept", int'(key_code), 5);
    chk("drop_valid", int'(key_valid), 1);
    key_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("drop_cleared", int'(key_valid), 0);
    repeat (FRAME - 3) @(negedge clk);
    run_frames(3, '0);

    // Long hold of key 0: single event, or auto-repeat in the repeat build
    exp_q.push_back(0);
`ifdef KEYPAD_REPEAT_EN
    repeat (4) exp_q.push_back(0);
`endif
    run_frames(14, key(0));
    run_frames(3, '0);
    chk("hold_drained", exp_q.size(), 0);

    // Reset in the middle of CONFIRM
    run_frames(2, key(6));
    repeat (8) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_col_out", int'(col_out), 4'b1110);
    chk("midrst_valid", int'(key_valid), 0);
    chk("midrst_held", int'(key_held), 0);
    chk("midrst_code", int'(key_code), 0);
    pressed = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_frames(4, '0);
    chk("midrst_no_event", int'(key_valid), 0);

    chk("final_queue", exp_q.size(), 0);
    chk("final_drops", drops, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
